// File: rtl/index_stream_vector_decoder_if.sv
// -----------------------------------------------------------------------------
// index_stream_vector_decoder_if
// Bundles the index stream input and the rebuilt-vector output of
// index_stream_vector_decoder.
//   master : the side that drives the index stream and the downstream ready
//            (a source/consumer pair or a testbench)
//   slave  : the decoder itself
// Signals
//   Enable_In            gates acceptance of indices
//   Index_Valid_In       Index_In / Index_Last_In valid this cycle
//   Index_In             encoded line number
//   Index_Last_In        beat closes the frame
//   Index_Ready_Out      decoder accepts an index this cycle
//   Vector_Valid_Out     rebuilt frame is presented
//   Vector_Out           rebuilt vector
//   Vector_Ready_In      downstream takes the vector
//   Index_Count_Out      accepted beats in the frame (saturating)
//   Duplicate_Error_Out  an index repeated within the frame
//   Range_Error_Out      an index >= VECTOR_WIDTH appeared within the frame
// -----------------------------------------------------------------------------
interface index_stream_vector_decoder_if #(
    parameter int INDEX_WIDTH  = 2,
    parameter int VECTOR_WIDTH = 4
);
    logic                     Enable_In;
    logic                     Index_Valid_In;
    logic [INDEX_WIDTH-1:0]   Index_In;
    logic                     Index_Last_In;
    logic                     Index_Ready_Out;
    logic                     Vector_Valid_Out;
    logic [VECTOR_WIDTH-1:0]  Vector_Out;
    logic                     Vector_Ready_In;
    logic [INDEX_WIDTH:0]     Index_Count_Out;
    logic                     Duplicate_Error_Out;
    logic                     Range_Error_Out;

    modport master (
        output Enable_In, Index_Valid_In, Index_In, Index_Last_In, Vector_Ready_In,
        input  Index_Ready_Out, Vector_Valid_Out, Vector_Out, Index_Count_Out,
               Duplicate_Error_Out, Range_Error_Out
    );

    modport slave (
        input  Enable_In, Index_Valid_In, Index_In, Index_Last_In, Vector_Ready_In,
        output Index_Ready_Out, Vector_Valid_Out, Vector_Out, Index_Count_Out,
               Duplicate_Error_Out, Range_Error_Out
    );
endinterface

// File: rtl/index_stream_vector_decoder.sv
// -----------------------------------------------------------------------------
// index_stream_vector_decoder
// Rebuilds a one-hot/multi-hot request vector from a stream of encoded
// indices (one per beat, frame closed by Index_Last_In) and presents it
// downstream under a valid/ready handshake.
// Ports
//   Clock_In   rising-edge clock
//   Reset_In   asynchronous active-high reset; discards any partial frame
//   bus        index_stream_vector_decoder_if.slave (stream in, vector out)
// Two-state FSM: COLLECT accumulates beats, PRESENT holds the registered
// frame until the downstream handshake. Frame outputs read 0 outside PRESENT.
// -----------------------------------------------------------------------------
module index_stream_vector_decoder #(
    parameter int INDEX_WIDTH  = 2,
    parameter int VECTOR_WIDTH = 4
) (
    input  logic Clock_In,
    input  logic Reset_In,
    index_stream_vector_decoder_if.slave bus
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    localparam logic [INDEX_WIDTH:0] COUNT_ONE = (INDEX_WIDTH+1)'(1);

    state_t                   state_r;
    logic [VECTOR_WIDTH-1:0]  acc_r;
    logic [INDEX_WIDTH:0]     count_r;
    logic                     dup_r;
    logic                     rng_r;
    logic [VECTOR_WIDTH-1:0]  vec_out_r;
    logic [INDEX_WIDTH:0]     count_out_r;
    logic                     dup_out_r;
    logic                     rng_out_r;
    logic                     valid_r;

    logic                     in_range_s;
    logic                     ready_s;
    logic                     accept_s;
    logic [VECTOR_WIDTH-1:0]  onehot_s;
    logic [VECTOR_WIDTH-1:0]  acc_next_s;
    logic [INDEX_WIDTH:0]     count_next_s;
    logic                     dup_hit_s;

    // With a full-width vector every index is in range, so no comparator is built.
    generate
        if (VECTOR_WIDTH >= (2 ** INDEX_WIDTH)) begin : g_full_range
            assign in_range_s = 1'b1;
        end else begin : g_partial_range
            localparam logic [INDEX_WIDTH:0] VEC_LIMIT = (INDEX_WIDTH+1)'(VECTOR_WIDTH);
            assign in_range_s = ({1'b0, bus.Index_In} < VEC_LIMIT);
        end
    endgenerate

    // Per-beat accumulate terms: handshake, decoded line, duplicate detect, saturating count.
    always_comb begin
        ready_s      = (state_r == ST_COLLECT) && bus.Enable_In && !Reset_In;
        accept_s     = ready_s && bus.Index_Valid_In;
        onehot_s     = in_range_s ? (VECTOR_WIDTH'(1'b1) << bus.Index_In) : '0;
        acc_next_s   = acc_r | onehot_s;
        dup_hit_s    = |(acc_r & onehot_s);
        count_next_s = (count_r == '1) ? count_r : (count_r + COUNT_ONE);
    end

    assign bus.Index_Ready_Out     = ready_s;
    assign bus.Vector_Valid_Out    = valid_r;
    assign bus.Vector_Out          = vec_out_r;
    assign bus.Index_Count_Out     = count_out_r;
    assign bus.Duplicate_Error_Out = dup_out_r;
    assign bus.Range_Error_Out     = rng_out_r;

    // Frame FSM: accumulation state and registered presentation outputs.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_r     <= ST_COLLECT;
            acc_r       <= '0;
            count_r     <= '0;
            dup_r       <= 1'b0;
            rng_r       <= 1'b0;
            vec_out_r   <= '0;
            count_out_r <= '0;
            dup_out_r   <= 1'b0;
            rng_out_r   <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (accept_s) begin
                        acc_r   <= acc_next_s;
                        count_r <= count_next_s;
                        dup_r   <= dup_r | dup_hit_s;
                        rng_r   <= rng_r | !in_range_s;
                        if (bus.Index_Last_In) begin
                            // Outputs capture the frame including this closing beat.
                            vec_out_r   <= acc_next_s;
                            count_out_r <= count_next_s;
                            dup_out_r   <= dup_r | dup_hit_s;
                            rng_out_r   <= rng_r | !in_range_s;
                            valid_r     <= 1'b1;
                            state_r     <= ST_PRESENT;
                        end else begin
                            state_r     <= ST_COLLECT;
                        end
                    end else begin
                        state_r <= ST_COLLECT;
                    end
                end
                ST_PRESENT: begin
                    if (bus.Vector_Ready_In) begin
                        acc_r       <= '0;
                        count_r     <= '0;
                        dup_r       <= 1'b0;
                        rng_r       <= 1'b0;
                        vec_out_r   <= '0;
                        count_out_r <= '0;
                        dup_out_r   <= 1'b0;
                        rng_out_r   <= 1'b0;
                        valid_r     <= 1'b0;
                        state_r     <= ST_COLLECT;
                    end else begin
                        state_r     <= ST_PRESENT;
                    end
                end
                default: begin
                    state_r <= ST_COLLECT;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_index_stream_vector_decoder.sv
module tb_index_stream_vector_decoder;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic       vld  = 1'b0;
    logic       last = 1'b0;
    logic       vrdy = 1'b0;
    logic [1:0] idx  = 2'd0;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    index_stream_vector_decoder_if #(.INDEX_WIDTH(2), .VECTOR_WIDTH(4)) if4 ();
    index_stream_vector_decoder_if #(.INDEX_WIDTH(2), .VECTOR_WIDTH(3)) if3 ();

    assign if4.Enable_In       = en;
    assign if4.Index_Valid_In  = vld;
    assign if4.Index_In        = idx;
    assign if4.Index_Last_In   = last;
    assign if4.Vector_Ready_In = vrdy;
    assign if3.Enable_In       = en;
    assign if3.Index_Valid_In  = vld;
    assign if3.Index_In        = idx;
    assign if3.Index_Last_In   = last;
    assign if3.Vector_Ready_In = vrdy;

    index_stream_vector_decoder #(.INDEX_WIDTH(2), .VECTOR_WIDTH(4)) dut4 (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (if4.slave)
    );

    index_stream_vector_decoder #(.INDEX_WIDTH(2), .VECTOR_WIDTH(3)) dut3 (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (if3.slave)
    );

    typedef struct {
        int         len;
        logic [17:0] idxs;
        logic [3:0] vec4;
        logic [2:0] vec3;
        int         cnt;
        logic       dup4;
        logic       dup3;
        logic       rng3;
    } frame_t;

    frame_t tbl [7];

    function automatic logic [17:0] pk(input int a0, input int a1 = 0, input int a2 = 0,
                                       input int a3 = 0, input int a4 = 0, input int a5 = 0,
                                       input int a6 = 0, input int a7 = 0, input int a8 = 0);
        return {2'(a8), 2'(a7), 2'(a6), 2'(a5), 2'(a4), 2'(a3), 2'(a2), 2'(a1), 2'(a0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drives one beat, holds it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [1:0] i, input logic l);
        int n;
        n    = 0;
        vld  = 1'b1;
        idx  = i;
        last = l;
        @(negedge clk);
        while (!if4.Index_Ready_Out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("beat_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        vld  = 1'b0;
        last = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [3:0] v4, input logic [2:0] v3,
                               input int cnt, input logic d4, input logic d3,
                               input logic r4, input logic r3);
        chk({tag, ".valid4"}, 32'(if4.Vector_Valid_Out), 32'd1);
        chk({tag, ".vec4"},   32'(if4.Vector_Out), 32'(v4));
        chk({tag, ".cnt4"},   32'(if4.Index_Count_Out), 32'(cnt));
        chk({tag, ".dup4"},   32'(if4.Duplicate_Error_Out), 32'(d4));
        chk({tag, ".rng4"},   32'(if4.Range_Error_Out), 32'(r4));
        chk({tag, ".rdy4"},   32'(if4.Index_Ready_Out), 32'd0);
        chk({tag, ".valid3"}, 32'(if3.Vector_Valid_Out), 32'd1);
        chk({tag, ".vec3"},   32'(if3.Vector_Out), 32'(v3));
        chk({tag, ".cnt3"},   32'(if3.Index_Count_Out), 32'(cnt));
        chk({tag, ".dup3"},   32'(if3.Duplicate_Error_Out), 32'(d3));
        chk({tag, ".rng3"},   32'(if3.Range_Error_Out), 32'(r3));
    endtask

    // Completes the output handshake and checks the outputs return to idle.
    task automatic finish_frame(input string tag);
        @(posedge clk);
        #1;
        vrdy = 1'b1;
        @(posedge clk);
        #1;
        vrdy = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_valid4"}, 32'(if4.Vector_Valid_Out), 32'd0);
        chk({tag, ".idle_vec4"},   32'(if4.Vector_Out), 32'd0);
        chk({tag, ".idle_valid3"}, 32'(if3.Vector_Valid_Out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] seen4;
        logic [2:0] seen3;
        logic       d4, d3, r3;
        int         len, cnt, gap;
        logic [1:0] bi;

        tbl[0] = '{len: 3, idxs: pk(3, 0, 2), vec4: 4'b1101, vec3: 3'b101, cnt: 3, dup4: 1'b0, dup3: 1'b0, rng3: 1'b1};
        tbl[1] = '{len: 1, idxs: pk(1), vec4: 4'b0010, vec3: 3'b010, cnt: 1, dup4: 1'b0, dup3: 1'b0, rng3: 1'b0};
        tbl[2] = '{len: 2, idxs: pk(2, 2), vec4: 4'b0100, vec3: 3'b100, cnt: 2, dup4: 1'b1, dup3: 1'b1, rng3: 1'b0};
        tbl[3] = '{len: 1, idxs: pk(0), vec4: 4'b0001, vec3: 3'b001, cnt: 1, dup4: 1'b0, dup3: 1'b0, rng3: 1'b0};
        tbl[4] = '{len: 2, idxs: pk(3, 1), vec4: 4'b1010, vec3: 3'b010, cnt: 2, dup4: 1'b0, dup3: 1'b0, rng3: 1'b1};
        tbl[5] = '{len: 9, idxs: pk(0, 1, 2, 3, 0, 1, 2, 3, 0), vec4: 4'b1111, vec3: 3'b111, cnt: 7, dup4: 1'b1, dup3: 1'b1, rng3: 1'b1};
        tbl[6] = '{len: 2, idxs: pk(3, 3), vec4: 4'b1000, vec3: 3'b000, cnt: 2, dup4: 1'b1, dup3: 1'b0, rng3: 1'b1};

        // Reset state, with enable already high.
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.ready4", 32'(if4.Index_Ready_Out), 32'd0);
        chk("rst.valid4", 32'(if4.Vector_Valid_Out), 32'd0);
        chk("rst.vec4",   32'(if4.Vector_Out), 32'd0);
        chk("rst.cnt4",   32'(if4.Index_Count_Out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.ready4", 32'(if4.Index_Ready_Out), 32'd1);
        @(posedge clk);
        #1;

        // Frame {3,0,2 Last} with downstream always ready: valid for exactly one cycle.
        vrdy = 1'b1;
        send_beat(2'd3, 1'b0);
        send_beat(2'd0, 1'b0);
        send_beat(2'd2, 1'b1);
        @(negedge clk);
        check_frame("f302", 4'b1101, 3'b101, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("f302.valid_drop", 32'(if4.Vector_Valid_Out), 32'd0);
        chk("f302.vec_zero",   32'(if4.Vector_Out), 32'd0);
        chk("f302.ready_back", 32'(if4.Index_Ready_Out), 32'd1);
        vrdy = 1'b0;
        @(posedge clk);
        #1;

        // Single beat {1 Last} held under backpressure for 5 cycles.
        send_beat(2'd1, 1'b1);
        @(negedge clk);
        check_frame("f1", 4'b0010, 3'b010, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("f1.hold_valid", 32'(if4.Vector_Valid_Out), 32'd1);
            chk("f1.hold_vec",   32'(if4.Vector_Out), 32'h2);
            chk("f1.hold_ready", 32'(if4.Index_Ready_Out), 32'd0);
        end
        @(posedge clk);
        #1;
        vrdy = 1'b1;
        @(negedge clk);
        chk("f1.valid_at_ready", 32'(if4.Vector_Valid_Out), 32'd1);
        @(negedge clk);
        chk("f1.valid_after", 32'(if4.Vector_Valid_Out), 32'd0);
        vrdy = 1'b0;
        @(posedge clk);
        #1;

        // Directed table of frames.
        for (int t = 0; t < 7; t++) begin
            for (int b = 0; b < tbl[t].len; b++) begin
                bi = tbl[t].idxs[2*b +: 2];
                send_beat(bi, (b == tbl[t].len - 1));
            end
            @(negedge clk);
            check_frame($sformatf("tbl%0d", t), tbl[t].vec4, tbl[t].vec3, tbl[t].cnt,
                        tbl[t].dup4, tbl[t].dup3, 1'b0, tbl[t].rng3);
            finish_frame($sformatf("tbl%0d", t));
            @(posedge clk);
            #1;
        end

        // Enable dropped mid-frame while a beat is offered.
        send_beat(2'd0, 1'b0);
        en   = 1'b0;
        vld  = 1'b1;
        idx  = 2'd3;
        last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("en_off.ready4", 32'(if4.Index_Ready_Out), 32'd0);
            chk("en_off.valid4", 32'(if4.Vector_Valid_Out), 32'd0);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        send_beat(2'd3, 1'b1);
        @(negedge clk);
        check_frame("en_resume", 4'b1001, 3'b001, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_frame("en_resume");
        @(posedge clk);
        #1;

        // Reset mid-frame discards the partial frame.
        send_beat(2'd1, 1'b0);
        send_beat(2'd2, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst.valid4", 32'(if4.Vector_Valid_Out), 32'd0);
        chk("mid_rst.vec4",   32'(if4.Vector_Out), 32'd0);
        chk("mid_rst.ready4", 32'(if4.Index_Ready_Out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat(2'd3, 1'b1);
        @(negedge clk);
        check_frame("post_rst", 4'b1000, 3'b000, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_frame("post_rst");
        @(posedge clk);
        #1;

        // Random frames against a reference model (OR of one-hot indices).
        for (int f = 0; f < 20; f++) begin
            len   = $urandom_range(1, 9);
            seen4 = 4'b0000;
            seen3 = 3'b000;
            d4    = 1'b0;
            d3    = 1'b0;
            r3    = 1'b0;
            for (int b = 0; b < len; b++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                bi = 2'($urandom_range(0, 3));
                if (seen4[bi]) d4 = 1'b1;
                seen4[bi] = 1'b1;
                if (bi < 2'd3) begin
                    if (seen3[bi]) d3 = 1'b1;
                    seen3[bi] = 1'b1;
                end else begin
                    r3 = 1'b1;
                end
                send_beat(bi, (b == len - 1));
            end
            cnt = (len > 7) ? 7 : len;
            @(negedge clk);
            check_frame($sformatf("rnd%0d", f), seen4, seen3, cnt, d4, d3, 1'b0, r3);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            chk($sformatf("rnd%0d.stall_valid", f), 32'(if4.Vector_Valid_Out), 32'd1);
            chk($sformatf("rnd%0d.stall_vec", f), 32'(if4.Vector_Out), 32'(seen4));
            finish_frame($sformatf("rnd%0d", f));
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
